// File: rtl/hawk_pkg.sv
// Shared types and defaults for the hawk AXI master arbiter.
package hawk_pkg;

   typedef enum logic [1:0] {
      ARB_OWN    = 2'd0,
      ARB_DRAIN  = 2'd1,
      ARB_SWITCH = 2'd2
   } hawk_arb_state_t;

   localparam int HAWK_QUANTUM_DFLT = 64;

endpackage

// File: rtl/hawk_ost_ctr.sv
// Outstanding-transaction up/down counter with zero/full flags.
// With HAWK_ARB_ERR_CHK_EN an underflow flag is added and the count holds at zero instead of wrapping.
module hawk_ost_ctr #(
   parameter int OST_W = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic full_o
`ifdef HAWK_ARB_ERR_CHK_EN
   ,
   output logic underflow_o
`endif
);

   localparam logic [OST_W-1:0] ONE_C = OST_W'(1'b1);

   logic [OST_W-1:0] cnt_q;
   logic [OST_W-1:0] cnt_d;

   // Simultaneous inc and dec cancel out.
   always_comb begin
      cnt_d = cnt_q;
      case ({inc_i, dec_i})
         2'b10: cnt_d = cnt_q + ONE_C;
         2'b01: begin
`ifdef HAWK_ARB_ERR_CHK_EN
            if (zero_o) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
`else
            cnt_d = cnt_q - ONE_C;
`endif
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= {OST_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == {OST_W{1'b0}});
   assign full_o = &cnt_q;

`ifdef HAWK_ARB_ERR_CHK_EN
   assign underflow_o = dec_i & ~inc_i & zero_o;
`endif

endmodule

// File: rtl/hawk_axi_mstr_arb.sv
// Transaction-aware two-master arbiter for the shared memory-controller AXI port.
// Optional HAWK_ARB_ERR_CHK_EN enables the sticky protocol-error flag on err_o.
module hawk_axi_mstr_arb
   import hawk_pkg::*;
#(
   parameter int OST_W   = 4,
   parameter int QUANTUM = HAWK_QUANTUM_DFLT,
   parameter int QNT_W   = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic m0_req_i,
   input  logic m1_req_i,
   input  logic aw_valid_i,
   input  logic aw_ready_i,
   input  logic w_valid_i,
   input  logic w_ready_i,
   input  logic w_last_i,
   input  logic b_valid_i,
   input  logic b_ready_i,
   input  logic ar_valid_i,
   input  logic ar_ready_i,
   input  logic r_valid_i,
   input  logic r_ready_i,
   input  logic r_last_i,
   output logic mstr_sel_o,
   output logic addr_allow_o,
   output logic err_o
);

   localparam logic [QNT_W-1:0] QCNT_LAST_C = QNT_W'(QUANTUM - 1);
   localparam logic [QNT_W-1:0] QCNT_ONE_C  = QNT_W'(1'b1);

   hawk_arb_state_t state_q, state_d;
   logic             sel_q, sel_d;
   logic [QNT_W-1:0] qcnt_q, qcnt_d;

   logic       aw_fire_s, ar_fire_s, b_fire_s, w_last_fire_s, r_last_fire_s;
   logic [2:0] inc_s, dec_s, zero_s, full_s;
   logic       drained_s, own_req_s, oth_req_s;

   assign aw_fire_s     = aw_valid_i & aw_ready_i;
   assign ar_fire_s     = ar_valid_i & ar_ready_i;
   assign b_fire_s      = b_valid_i & b_ready_i;
   assign w_last_fire_s = w_valid_i & w_ready_i & w_last_i;
   assign r_last_fire_s = r_valid_i & r_ready_i & r_last_i;

   // Counter lanes: [0] write responses, [1] write data, [2] reads.
   assign inc_s = {ar_fire_s, aw_fire_s, aw_fire_s};
   assign dec_s = {r_last_fire_s, w_last_fire_s, b_fire_s};

`ifdef HAWK_ARB_ERR_CHK_EN
   logic [2:0] uf_s;
`endif

   for (genvar i = 0; i < 3; i++) begin : g_ctr
      hawk_ost_ctr #(.OST_W(OST_W)) u_ctr (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .inc_i       (inc_s[i]),
         .dec_i       (dec_s[i]),
         .zero_o      (zero_s[i]),
         .full_o      (full_s[i])
`ifdef HAWK_ARB_ERR_CHK_EN
         ,
         .underflow_o (uf_s[i])
`endif
      );
   end

   assign drained_s = &zero_s;
   assign own_req_s = sel_q ? m1_req_i : m0_req_i;
   assign oth_req_s = sel_q ? m0_req_i : m1_req_i;

   // Ownership FSM: hand over immediately when the owner is idle on a drained port,
   // otherwise after the hold quantum expires and the port drains.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      qcnt_d       = qcnt_q;
      addr_allow_o = 1'b0;
      case (state_q)
         ARB_OWN: begin
            addr_allow_o = ~|full_s;
            if (oth_req_s && !own_req_s && drained_s) begin
               state_d = ARB_SWITCH;
               qcnt_d  = {QNT_W{1'b0}};
            end else if (oth_req_s) begin
               if (qcnt_q == QCNT_LAST_C) begin
                  state_d = ARB_DRAIN;
               end else begin
                  qcnt_d = qcnt_q + QCNT_ONE_C;
               end
            end else begin
               qcnt_d = {QNT_W{1'b0}};
            end
         end
         ARB_DRAIN: begin
            if (drained_s) begin
               state_d = ARB_SWITCH;
            end else begin
               state_d = ARB_DRAIN;
            end
         end
         ARB_SWITCH: begin
            sel_d   = ~sel_q;
            qcnt_d  = {QNT_W{1'b0}};
            state_d = ARB_OWN;
         end
         default: begin
            state_d = ARB_OWN;
            qcnt_d  = {QNT_W{1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_OWN;
         sel_q   <= 1'b0;
         qcnt_q  <= {QNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         qcnt_q  <= qcnt_d;
      end
   end

   assign mstr_sel_o = sel_q;

`ifdef HAWK_ARB_ERR_CHK_EN
   logic err_q;

   // Sticky until reset: counter underflow or an address fire while address issue is blocked.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if ((|uf_s) || ((aw_fire_s || ar_fire_s) && !addr_allow_o)) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
